// File: rtl/cam_avst_packetizer.sv
// cam_avst_packetizer
//   Converts a free-running RGB565 camera pixel stream (no backpressure) into
//   Avalon-ST video packets. Each packet is a one-beat control header (type 0)
//   followed by IMG_W*IMG_H RGB 10:10:10 pixel beats. A small FIFO absorbs
//   downstream stalls. If the FIFO overflows, or a new SOF arrives before the
//   frame is complete, the packet is closed with an all-zero terminator beat
//   carrying endofpacket, and the sticky overflow flag is raised.
//
// Ports
//   clk_clk, reset_reset_n        : clock, async active-low reset
//   cam_valid/cam_sof/cam_data    : camera pixel strobe, frame start, RGB565
//   src_data/src_valid/src_ready  : Avalon-ST source (30-bit RGB beat)
//   src_startofpacket/endofpacket : packet framing
//   clr_status                    : synchronous clear of overflow, frame_count
//   overflow                      : sticky drop / early-SOF indicator
//   frame_count                   : complete frames emitted (wraps)
module cam_avst_packetizer #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        cam_valid,
  input  logic        cam_sof,
  input  logic [15:0] cam_data,
  output logic [29:0] src_data,
  output logic        src_valid,
  input  logic        src_ready,
  output logic        src_startofpacket,
  output logic        src_endofpacket,
  input  logic        clr_status,
  output logic        overflow,
  output logic [15:0] frame_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int PCW  = $clog2(NPIX) + 1;

  localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [PCW-1:0] LAST_PIX = PCW'(NPIX - 1);
  localparam logic           ONE_PIX  = (NPIX == 1);

  // term marks a writer-generated terminator so its eop does not count a frame
  typedef struct packed {
    logic        sof;
    logic        eop;
    logic        term;
    logic [29:0] data;
  } fifo_entry_t;

  typedef enum logic [1:0] {W_WAIT, W_RUN, W_TERM} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_HDR, R_PIX}  rstate_t;

  // Colour expansion: replicate MSBs into the new LSBs
  logic [29:0] pix30;
  assign pix30 = {cam_data[15:11], cam_data[15:11],
                  cam_data[10:5],  cam_data[10:7],
                  cam_data[4:0],   cam_data[4:0]};

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  fifo_entry_t       mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              full, empty;
  fifo_entry_t       head;
  fifo_entry_t       wr_entry;
  logic              push, pop;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Writer FSM
  // ---------------------------------------------------------------------------
  wstate_t        wstate_q, wstate_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic           ovf_set;

  always_comb begin
    wstate_d = wstate_q;
    pcnt_d   = pcnt_q;
    push     = 1'b0;
    wr_entry = '0;
    ovf_set  = 1'b0;
    case (wstate_q)
      W_WAIT: begin
        if (cam_valid && cam_sof) begin
          if (full) begin
            // no room even for the first pixel: drop and keep waiting
            ovf_set = 1'b1;
          end else begin
            push          = 1'b1;
            wr_entry.sof  = 1'b1;
            wr_entry.eop  = ONE_PIX;
            wr_entry.data = pix30;
            pcnt_d        = PCW'(1);
            wstate_d      = ONE_PIX ? W_WAIT : W_RUN;
          end
        end
      end
      W_RUN: begin
        if (cam_valid) begin
          if (cam_sof || full) begin
            ovf_set  = 1'b1;
            wstate_d = W_TERM;
          end else begin
            push          = 1'b1;
            wr_entry.data = pix30;
            pcnt_d        = pcnt_q + PCW'(1);
            if (pcnt_q == LAST_PIX) begin
              wr_entry.eop = 1'b1;
              wstate_d     = W_WAIT;
            end
          end
        end
      end
      W_TERM: begin
        // camera pixels are ignored here; close the packet as soon as there is room
        if (!full) begin
          push          = 1'b1;
          wr_entry.eop  = 1'b1;
          wr_entry.term = 1'b1;
          wstate_d      = W_WAIT;
        end
      end
      default: wstate_d = W_WAIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Reader FSM (drives the Avalon-ST source combinationally from state + head)
  // ---------------------------------------------------------------------------
  rstate_t rstate_q, rstate_d;
  logic    fc_inc;

  always_comb begin
    rstate_d          = rstate_q;
    pop               = 1'b0;
    fc_inc            = 1'b0;
    src_valid         = 1'b0;
    src_startofpacket = 1'b0;
    src_endofpacket   = 1'b0;
    src_data          = '0;
    case (rstate_q)
      R_IDLE: begin
        if (!empty) begin
          if (head.sof) rstate_d = R_HDR;
          else          pop      = 1'b1;   // stale entry outside a packet
        end
      end
      R_HDR: begin
        src_valid         = 1'b1;
        src_startofpacket = 1'b1;
        if (src_ready) rstate_d = R_PIX;
      end
      R_PIX: begin
        src_valid = !empty;
        if (!empty) begin
          src_data        = head.data;
          src_endofpacket = head.eop;
          if (src_ready) begin
            pop = 1'b1;
            if (head.eop) begin
              rstate_d = R_IDLE;
              fc_inc   = !head.term;
            end
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO pointer/count next state. Full blocks a write even if a pop happens
  // the same cycle, so the writer only needs the registered count.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // ---------------------------------------------------------------------------
  // Status: a set event beats a coincident clear; for frame_count the clear
  // takes priority over a same-cycle increment.
  // ---------------------------------------------------------------------------
  logic        ovf_q, ovf_d;
  logic [15:0] fc_q, fc_d;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set)         ovf_d = 1'b1;
    else if (clr_status) ovf_d = 1'b0;
    fc_d = fc_q + 16'(fc_inc);
    if (clr_status) fc_d = '0;
  end

  assign overflow    = ovf_q;
  assign frame_count = fc_q;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wstate_q <= W_WAIT;
      rstate_q <= R_IDLE;
      pcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      fc_q     <= '0;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      pcnt_q   <= pcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      fc_q     <= fc_d;
    end
  end

  // Storage needs no reset: entries are only observed while cnt_q says valid
  always_ff @(posedge clk_clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

endmodule

// File: doc/cam_avst_packetizer.md
CAM_AVST_PACKETIZER -- requirements
Module: cam_avst_packetizer

Interface
REQ-001 SHALL have parameter IMG_W, default 640, pixels per line.
REQ-002 SHALL have parameter IMG_H, default 480, lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, buffer entries, power of 2, >=4.
REQ-004 SHALL have port clk_clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset_reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cam_valid  input  1  camera pixel strobe, no backpressure.
REQ-007 SHALL have port cam_sof  input  1  qualifies first pixel of frame when cam_valid=1.
REQ-008 SHALL have port cam_data  input  16  RGB565 pixel: [15:11]=R, [10:5]=G, [4:0]=B.
REQ-009 SHALL have port src_data  output  30  Avalon-ST video beat: [29:20]=R, [19:10]=G, [9:0]=B.
REQ-010 SHALL have port src_valid  output  1  beat valid.
REQ-011 SHALL have port src_ready  input  1  downstream scaler sink ready.
REQ-012 SHALL have port src_startofpacket  output  1  first beat of packet.
REQ-013 SHALL have port src_endofpacket  output  1  last beat of packet.
REQ-014 SHALL have port clr_status  input  1  synchronous clear of overflow and frame_count.
REQ-015 SHALL have port overflow  output  1  sticky, set on any dropped pixel or early SOF.
REQ-016 SHALL have port frame_count  output  16  complete frames emitted, wraps 0xFFFF->0.

Function
REQ-017 Colour expansion SHALL be R10={R5,R5}, G10={G6,G6[5:2]}, B10={B5,B5}; pure combinational before FIFO write.
REQ-018 FIFO entries SHALL hold {sof_tag, eop_tag, data30}; write and read same cycle allowed when neither full nor empty.
REQ-019 Writer FSM states: W_WAIT, W_RUN, W_TERM; reset state W_WAIT.
REQ-020 W_WAIT: discard pixels until cam_valid&cam_sof; that pixel written with sof_tag=1, pixel counter=1, -> W_RUN.
REQ-021 W_RUN: each cam_valid pixel written; pixel IMG_W*IMG_H-1 (0-based) written with eop_tag=1 -> W_WAIT.
REQ-022 W_RUN, cam_valid with FIFO full: pixel dropped, overflow=1, -> W_TERM.
REQ-023 W_RUN, cam_valid&cam_sof before final pixel: that pixel dropped, overflow=1, -> W_TERM.
REQ-024 W_TERM: on first cycle FIFO not full, write terminator {0,1,30'd0} -> W_WAIT; all cam pixels in W_TERM discarded.
REQ-025 Reader FSM states: R_IDLE, R_HDR, R_PIX; reset state R_IDLE.
REQ-026 R_IDLE: when FIFO head has sof_tag=1 -> R_HDR; head with sof_tag=0 SHALL be popped and discarded.
REQ-027 R_HDR: src_valid=1, src_startofpacket=1, src_endofpacket=0, src_data=30'd0 (type 0 video); on src_ready -> R_PIX, no pop.
REQ-028 R_PIX: src_valid=!empty, src_data=head data, src_endofpacket=head eop_tag, sop=0; pop on src_valid&src_ready.
REQ-029 Pop of eop_tag entry SHALL -> R_IDLE and increment frame_count unless that entry is a terminator (data=0 from W_TERM path; tracked by extra FIFO bit).
REQ-030 Outputs src_* SHALL be stable while src_valid=1 and src_ready=0.
REQ-031 Latency: pixel written at edge n SHALL be presentable at output from cycle n+1 (minimum header-to-first-pixel gap zero).
REQ-032 overflow SHALL set on event cycle; clr_status same cycle as set event: set wins.

Reset
REQ-033 On reset_reset_n=0: FIFO empty, both FSMs to initial state, src_valid=0, src_startofpacket=0, src_endofpacket=0, src_data=0, overflow=0, frame_count=0.
REQ-034 Reset mid-frame SHALL discard all buffered pixels; first packet after reset begins only at next cam_sof.

Verification (IMG_W=4, IMG_H=2, FIFO_DEPTH=4)
REQ-035 Clean frame, src_ready=1: 8 pixels 0xF800.. with sof on first -> header 30'd0 sop=1, then 8 beats, first 0x3FF00000, eop on 8th, frame_count=1.
REQ-036 Backpressure: src_ready=0 after header, 5 pixels -> 4 buffered, 5th dropped, overflow=1; release ready -> 4 beats then terminator 30'd0 eop=1, frame_count=0.
REQ-037 Early SOF: sof at pixel 3 -> terminator eop after pixel 2, overflow=1; following clean frame emits full packet, frame_count=1.
REQ-038 Pre-SOF junk: 3 pixels without sof then clean frame -> no output until sof, exactly one packet.
REQ-039 Async reset asserted mid-packet with ready toggling -> all outputs 0 immediately; next frame emits full packet with sop.
REQ-040 clr_status coincident with overflow event -> overflow stays 1; next cycle clr_status alone -> 0.
